spi_sl: RTL

Three-wire SPI target (slave) that terminates the team's SPI bus: it decodes the read/write bit, address and data arriving on `sdio`, and owns a small register file. It writes that file on write frames and drives register contents back on `sdio` for read frames. It sits on the peripheral side of the bus, opposite the SPI initiator. A local host port gives on-chip logic access to the same registers.

---
 rtl/spi_sl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_sl.sv
// Three-wire SPI target with a local register file. SPI pins are synchronized
// into clk; frames are R/W bit, address, then data, all MSB first.
module spi_sl #(
  parameter int a_width = 8,
  parameter int d_width = 16,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs,
  inout  wire logic          sdio,
  input  logic               host_we,
  input  logic [a_width-1:0] host_addr,
  input  logic [d_width-1:0] host_wdata,
  output logic [d_width-1:0] host_rdata,
  output logic               wr_strobe,
  output logic [a_width-1:0] wr_addr,
  output logic               frame_abort,
  output logic [2:0]         o_dbg_state
);

  localparam int CW = $clog2(((a_width > d_width) ? a_width : d_width) + 1);
  localparam int IW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [a_width:0] DEPTH_W = (a_width + 1)'(depth);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic in_range(input logic [a_width-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  logic               r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic               r_cs_s1, r_cs_s2;
  logic               r_sdi_s1, r_sdi_s2;
  logic [1:0]         r_sync_vld;
  logic               r_armed;
  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic [a_width-1:0] r_addr, w_addr_next;
  logic               r_rw, w_rw_next;
  logic [d_width-1:0] r_shift, w_shift_next;
  logic               r_sdo, w_sdo_next;
  logic               r_oe, w_oe_next;
  logic               w_spi_we, w_abort;
  logic [d_width-1:0] r_regs [depth];

  logic               w_rise, w_fall, w_host_in;
  logic [a_width-1:0] w_addr_sh;
  logic [d_width-1:0] w_data_sh, w_rd_val;

  assign w_rise      = r_sclk_s2 & ~r_sclk_prev;
  assign w_fall      = ~r_sclk_s2 & r_sclk_prev;
  assign w_addr_sh   = {r_addr[a_width-2:0], r_sdi_s2};
  assign w_data_sh   = {r_shift[d_width-2:0], r_sdi_s2};
  assign w_rd_val    = in_range(w_addr_sh) ? r_regs[w_addr_sh[IW-1:0]] : '0;
  assign w_host_in   = in_range(host_addr);
  assign sdio        = (r_state == RDATA && r_oe) ? r_sdo : 1'bz;
  assign o_dbg_state = r_state;

  // Synchronizer stages only reflect the pins two cycles after reset; a frame
  // may start only after cs has been seen high, so a reset mid-frame waits for cs to cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_cs_s1     <= 1'b1;
      r_cs_s2     <= 1'b1;
      r_sdi_s1    <= 1'b0;
      r_sdi_s2    <= 1'b0;
      r_sync_vld  <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_s1   <= sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_cs_s1     <= cs;
      r_cs_s2     <= r_cs_s1;
      r_sdi_s1    <= sdio;
      r_sdi_s2    <= r_sdi_s1;
      r_sync_vld  <= {r_sync_vld[0], 1'b1};
      r_armed     <= r_armed | (r_sync_vld[1] & r_cs_s2);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_rw_next    = r_rw;
    w_shift_next = r_shift;
    w_sdo_next   = r_sdo;
    w_oe_next    = r_oe;
    w_spi_we     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        w_oe_next  = 1'b0;
        w_sdo_next = 1'b0;
        if (r_armed && !r_cs_s2) begin
          w_cnt_next   = '0;
          w_state_next = CMD;
        end
      end
      CMD, ADDR, WDATA, RDATA: begin
        if (r_cs_s2) begin
          w_abort      = 1'b1;
          w_oe_next    = 1'b0;
          w_state_next = IDLE;
        end else if (r_state == CMD) begin
          if (w_rise) begin
            w_rw_next    = r_sdi_s2;
            w_cnt_next   = CW'(a_width);
            w_state_next = ADDR;
          end
        end else if (r_state == ADDR) begin
          if (w_rise) begin
            w_addr_next = w_addr_sh;
            w_cnt_next  = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              w_cnt_next = CW'(d_width);
              if (r_rw) begin
                w_shift_next = w_rd_val;
                w_state_next = RDATA;
              end else begin
                w_state_next = WDATA;
              end
            end
          end
        end else if (r_state == WDATA) begin
          if (w_rise) begin
            w_shift_next = w_data_sh;
            w_cnt_next   = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              w_spi_we     = in_range(r_addr);
              w_state_next = DONE;
            end
          end
        end else begin
          // Read data changes on falls; the final bit is held until the closing rise.
          if (w_fall && r_cnt != '0) begin
            w_sdo_next   = r_shift[d_width-1];
            w_shift_next = {r_shift[d_width-2:0], 1'b0};
            w_cnt_next   = r_cnt - 1'b1;
            w_oe_next    = 1'b1;
          end else if (w_rise && r_cnt == '0) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_oe_next = 1'b0;
        if (r_cs_s2) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_shift     <= '0;
      r_sdo       <= 1'b0;
      r_oe        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      frame_abort <= 1'b0;
      host_rdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_addr      <= w_addr_next;
      r_rw        <= w_rw_next;
      r_shift     <= w_shift_next;
      r_sdo       <= w_sdo_next;
      r_oe        <= w_oe_next;
      wr_strobe   <= w_spi_we;
      if (w_spi_we) wr_addr <= r_addr;
      frame_abort <= w_abort;
      host_rdata  <= w_host_in ? r_regs[host_addr[IW-1:0]] : '0;
    end
  end

  // Host port is strobe-only: host_we writes in the cycle it is high; host_rdata
  // follows host_addr one cycle later. An SPI commit to the same register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (w_spi_we && r_addr[IW-1:0] == IW'(i))
          r_regs[i] <= w_data_sh;
        else if (host_we && w_host_in && host_addr[IW-1:0] == IW'(i))
          r_regs[i] <= host_wdata;
      end
    end
  end

endmodule
